// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the two-port SRAM access scheduler.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 18;
    localparam int RAM_DATA_W = 16;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_WAIT,
        DONE
    } ram_arb_state_t;

endpackage

// File: rtl/ram_rr_arbiter.sv
// Two-way grant selection for the SRAM scheduler; grant is the winning port index.
// Defining RAM_ARB_FIXED_PRIO_EN gives port 0 absolute priority instead of round-robin.
module ram_rr_arbiter (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_inputs;
    assign unused_inputs = last_grant ^ req1;

    always_comb begin
        grant = !req0;
    end
`else
    // Under contention the port that did not win last time goes next.
    always_comb begin
        if (req0 && req1) begin
            grant = !last_grant;
        end else begin
            grant = !req0;
        end
    end
`endif

endmodule

// File: rtl/ram_access_scheduler.sv
// Shares one asynchronous SRAM between two requesters using counter-timed strobe windows.
// Arbitration mode is selected by RAM_ARB_FIXED_PRIO_EN (see ram_rr_arbiter).
module ram_access_scheduler
    import ram_arb_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int WE_CYC    = 2,
    parameter int HOLD_CYC  = 1,
    parameter int RD_CYC    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [RAM_ADDR_W-1:0] addr0,
    input  logic [RAM_ADDR_W-1:0] addr1,
    input  logic [RAM_DATA_W-1:0] wdata0,
    input  logic [RAM_DATA_W-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [RAM_DATA_W-1:0] rdata,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    inout  wire  [RAM_DATA_W-1:0] ram_data,
    output ram_arb_state_t        dbg_state
);

    ram_arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  port_q, port_d;
    logic                  we_q, we_d;
    logic [RAM_DATA_W-1:0] wdata_q, wdata_d;
    logic                  last_grant_q, last_grant_d;
    logic                  ce_n_q, ce_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;
    logic [RAM_ADDR_W-1:0] addr_q, addr_d;
    logic                  data_oe_q, data_oe_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [RAM_DATA_W-1:0] rdata_q, rdata_d;
    logic                  grant;
    logic                  cnt_last;

    ram_rr_arbiter u_arb (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign cnt_last = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        ce_n_d       = ce_n_q;
        oe_n_d       = oe_n_q;
        we_n_d       = we_n_q;
        addr_d       = addr_q;
        data_oe_d    = data_oe_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata_d      = rdata_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    port_d       = grant;
                    last_grant_d = grant;
                    we_d         = grant ? we1 : we0;
                    wdata_d      = grant ? wdata1 : wdata0;
                    addr_d       = grant ? addr1 : addr0;
                    // Write data goes onto the bus together with ce_n so it is stable for all of SETUP.
                    data_oe_d    = grant ? we1 : we0;
                    ce_n_d       = 1'b0;
                    cnt_d        = CNT_W'(SETUP_CYC);
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                if (cnt_last) begin
                    if (we_q) begin
                        we_n_d  = 1'b0;
                        cnt_d   = CNT_W'(WE_CYC);
                        state_d = WR_PULSE;
                    end else begin
                        oe_n_d  = 1'b0;
                        cnt_d   = CNT_W'(RD_CYC);
                        state_d = RD_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_PULSE: begin
                if (cnt_last) begin
                    we_n_d  = 1'b1;
                    cnt_d   = CNT_W'(HOLD_CYC);
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                if (cnt_last) begin
                    data_oe_d = 1'b0;
                    ce_n_d    = 1'b1;
                    ack0_d    = !port_q;
                    ack1_d    = port_q;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_WAIT: begin
                if (cnt_last) begin
                    rdata_d = ram_data;
                    oe_n_d  = 1'b1;
                    ce_n_d  = 1'b1;
                    ack0_d  = !port_q;
                    ack1_d  = port_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            addr_q       <= '0;
            data_oe_q    <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            addr_q       <= addr_d;
            data_oe_q    <= data_oe_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata_q      <= rdata_d;
        end
    end

    assign ram_data  = data_oe_q ? wdata_q : {RAM_DATA_W{1'bz}};
    assign ram_ce_n  = ce_n_q;
    assign ram_oe_n  = oe_n_q;
    assign ram_we_n  = we_n_q;
    assign ram_addr  = addr_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: doc/ram_access_scheduler.md
Name: ram_access_scheduler

Overview:
- Clocked two-port scheduler that shares one asynchronous 256K x 16 SRAM between two requesters (port 0: UART-RX write path, port 1: UART-TX read path).
- Arbitrates between the ports and sequences SRAM strobes with cycle-counted setup, pulse, hold and read-access windows.
- Sits between the UART front ends and the SRAM pins, replacing delay-based strobe timing with synthesizable counters.

Parameters:
- SETUP_CYC, 2, cycles ram_ce_n is low with address/data stable before the strobe; legal range 1..15.
- WE_CYC, 2, ram_we_n low-pulse width in cycles; legal range 1..15.
- HOLD_CYC, 1, cycles address/data are held after ram_we_n rises; legal range 1..15.
- RD_CYC, 3, cycles ram_oe_n is low before read data is captured; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request; held high until ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req high.
- addr0 / addr1  in  18  word address.
- wdata0 / wdata1  in  16  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata  out  16  read data; valid in the ack cycle of a read, held until the next read completes.
- ram_ce_n, ram_oe_n, ram_we_n  out  1  SRAM strobes, active low.
- ram_addr  out  18  SRAM address.
- ram_data  inout  16  SRAM data bus.

Behaviour:
- Reset values:
  - state = IDLE.
  - ram_ce_n = ram_oe_n = ram_we_n = 1; ram_addr = 0; ram_data = Z.
  - ack0 = ack1 = 0; rdata = 0.
  - last_grant = 1, so port 0 wins the first contention.
- All SRAM-side outputs and acks are registered; no combinational path from req to pins.
- States: IDLE, SETUP, WR_PULSE, WR_HOLD, RD_WAIT, DONE. A 4-bit down-counter times every state except IDLE and DONE.
- IDLE:
  - If any req is high, grant one port.
  - On the grant edge, latch that port's we/addr/wdata, load the counter with SETUP_CYC, drive ram_ce_n low and ram_addr, and go to SETUP.
  - With both ports requesting, grant the port not equal to last_grant, then update last_grant.
- SETUP:
  - On write, ram_data is driven with the latched wdata.
  - On expiry: a write goes to WR_PULSE (ram_we_n low, counter = WE_CYC); a read goes to RD_WAIT (ram_oe_n low, counter = RD_CYC).
- WR_PULSE: on expiry, ram_we_n goes high and the state moves to WR_HOLD with counter = HOLD_CYC. Data is still driven.
- WR_HOLD: on expiry, ram_data is released to Z, ram_ce_n goes high, and the state moves to DONE.
- RD_WAIT: on expiry, ram_data is captured into rdata, ram_oe_n and ram_ce_n go high, and the state moves to DONE.
- DONE: the granted port's ack is high for exactly this cycle; the next state is IDLE.
- Latency, counting from the cycle req is sampled in IDLE as cycle 0:
  - Write ack in cycle 1+SETUP_CYC+WE_CYC+HOLD_CYC; 6 with defaults.
  - Read ack in cycle 1+SETUP_CYC+RD_CYC; 6 with defaults.
  - Minimum one IDLE cycle between accesses.
- Requester handshake: the requester drops req on the edge where it sees ack. If req is still high in the following IDLE cycle, it is a new request.
- Requests arriving mid-access wait in IDLE arbitration; a losing request is never dropped.
- ram_data is driven only from SETUP through WR_HOLD of a write; never driven while ram_oe_n is low.
- A reset mid-access aborts the access on the next edge: all strobes high, bus Z, no ack issued. The SRAM contents at the aborted address are undefined.
- A non-granted port's input changes have no effect on the access in flight.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins simultaneous requests; last_grant is unused. Port 1 can starve.
- Undefined: round-robin as described above.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum typedef ram_arb_state_t;
  - constants RAM_ADDR_W = 18, RAM_DATA_W = 16, CNT_W = 4.
- Sub-module ram_rr_arbiter holds the 2-way grant logic: inputs req0/req1/last_grant, outputs the grant index. The macro is handled inside this sub-module.

Test Plan:
- Port 0 write, addr 0x00012, wdata 0xA5A5 -> ram_we_n low exactly in cycles 3-4; ram_data = 0xA5A5 in cycles 1-5; ack0 in cycle 6.
- Port 1 read of 0x00012 with the SRAM model returning 0xA5A5 -> ram_oe_n low in cycles 3-5; rdata = 0xA5A5 and ack1 in cycle 6; ram_data never driven.
- req0 and req1 rise together, held continuously -> grant order 0, 1, 0, 1 without the macro; 0, 0, 0 with RAM_ARB_FIXED_PRIO_EN.
- req1 asserted during a port 0 write -> port 1 is granted in the first IDLE after ack0; no request is lost.
- rst pulsed during WR_PULSE -> next edge: ram_we_n = ram_ce_n = 1, ram_data = Z, no ack0, state IDLE.
- Parameters set to 1 (SETUP/WE/HOLD/RD) -> write ack in cycle 4 and read ack in cycle 3; strobe widths are exactly 1 cycle.
